// File: rtl/pipe_hazard_tracker.sv
// Front-end pipeline latches (IF/ID, ID/EX, EX/MEM) driven by hazard-unit freeze/flush
// and memory hit status, with saturating freeze/flush statistics.
module pipe_hazard_tracker #(
    parameter int                WORD_W   = 32,
    parameter logic [WORD_W-1:0] NOP_WORD = 32'h00000000,
    parameter int                CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              freeze,
    input  logic              flush,
    input  logic [WORD_W-1:0] imemload,
    input  logic [WORD_W-1:0] pc,
    output logic              pc_en,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] idex_instr,
    output logic [WORD_W-1:0] exmem_instr,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] idex_pc,
    output logic              ifid_valid,
    output logic              idex_valid,
    output logic              exmem_valid,
    output logic              mem_stall,
    output logic [CNT_W-1:0]  freeze_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [2:0] {
        M_HOLD   = 3'd0,
        M_FLUSH  = 3'd1,
        M_FREEZE = 3'd2,
        M_MISS   = 3'd3,
        M_ADV    = 3'd4
    } mode_t;

    logic [WORD_W-1:0] r_ifid_instr, r_idex_instr, r_exmem_instr;
    logic [WORD_W-1:0] r_ifid_pc, r_idex_pc;
    logic              r_ifid_valid, r_idex_valid, r_exmem_valid;
    logic [CNT_W-1:0]  r_freeze_cnt, r_flush_cnt;

    logic              w_is_mem_op;
    logic              w_mem_stall;
    logic              w_pc_en;
    mode_t             w_mode;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign w_is_mem_op = (r_exmem_instr[31:26] == OP_LW) || (r_exmem_instr[31:26] == OP_SW);
    assign w_mem_stall = r_exmem_valid & w_is_mem_op & ~dhit;

    // Priority decode of this cycle's pipeline action
    always_comb begin
        w_mode = M_ADV;
        if (w_mem_stall) begin
            w_mode = M_HOLD;
        end else if (flush) begin
            w_mode = M_FLUSH;
        end else if (freeze) begin
            w_mode = M_FREEZE;
        end else if (!ihit) begin
            w_mode = M_MISS;
        end else begin
            w_mode = M_ADV;
        end
    end

    // PC may only move on flush or a clean advance, never while reset is applied
    assign w_pc_en = ~RST & ((w_mode == M_FLUSH) || (w_mode == M_ADV));

    // Pipeline latches and statistics counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ifid_instr  <= NOP_WORD;
            r_idex_instr  <= NOP_WORD;
            r_exmem_instr <= NOP_WORD;
            r_ifid_pc     <= '0;
            r_idex_pc     <= '0;
            r_ifid_valid  <= 1'b0;
            r_idex_valid  <= 1'b0;
            r_exmem_valid <= 1'b0;
            r_freeze_cnt  <= '0;
            r_flush_cnt   <= '0;
        end else begin
            case (w_mode)
                M_FLUSH: begin
                    r_ifid_instr  <= NOP_WORD;
                    r_ifid_pc     <= '0;
                    r_ifid_valid  <= 1'b0;
                    r_idex_instr  <= NOP_WORD;
                    r_idex_pc     <= '0;
                    r_idex_valid  <= 1'b0;
                    r_exmem_instr <= r_idex_instr;
                    r_exmem_valid <= r_idex_valid;
                    r_flush_cnt   <= sat_inc(r_flush_cnt);
                end
                M_FREEZE: begin
                    r_idex_instr  <= NOP_WORD;
                    r_idex_pc     <= '0;
                    r_idex_valid  <= 1'b0;
                    r_exmem_instr <= r_idex_instr;
                    r_exmem_valid <= r_idex_valid;
                    r_freeze_cnt  <= sat_inc(r_freeze_cnt);
                end
                M_MISS: begin
                    r_ifid_instr  <= NOP_WORD;
                    r_ifid_pc     <= '0;
                    r_ifid_valid  <= 1'b0;
                    r_idex_instr  <= r_ifid_instr;
                    r_idex_pc     <= r_ifid_pc;
                    r_idex_valid  <= r_ifid_valid;
                    r_exmem_instr <= r_idex_instr;
                    r_exmem_valid <= r_idex_valid;
                end
                M_ADV: begin
                    r_ifid_instr  <= imemload;
                    r_ifid_pc     <= pc;
                    r_ifid_valid  <= 1'b1;
                    r_idex_instr  <= r_ifid_instr;
                    r_idex_pc     <= r_ifid_pc;
                    r_idex_valid  <= r_ifid_valid;
                    r_exmem_instr <= r_idex_instr;
                    r_exmem_valid <= r_idex_valid;
                end
                default: begin
                    r_ifid_instr  <= r_ifid_instr;
                    r_exmem_valid <= r_exmem_valid;
                end
            endcase
        end
    end

    assign pc_en       = w_pc_en;
    assign mem_stall   = w_mem_stall;
    assign ifid_instr  = r_ifid_instr;
    assign idex_instr  = r_idex_instr;
    assign exmem_instr = r_exmem_instr;
    assign ifid_pc     = r_ifid_pc;
    assign idex_pc     = r_idex_pc;
    assign ifid_valid  = r_ifid_valid;
    assign idex_valid  = r_idex_valid;
    assign exmem_valid = r_exmem_valid;
    assign freeze_cnt  = r_freeze_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed-vector bench for pipe_hazard_tracker with hand-computed expectations.
module tb_pipe_hazard_tracker;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, freeze, flush;
    logic [31:0] imemload, pc;
    logic        pc_en, mem_stall;
    logic [31:0] ifid_instr, idex_instr, exmem_instr, ifid_pc, idex_pc;
    logic        ifid_valid, idex_valid, exmem_valid;
    logic [15:0] freeze_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_tracker dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .freeze(freeze), .flush(flush),
        .imemload(imemload), .pc(pc), .pc_en(pc_en),
        .ifid_instr(ifid_instr), .idex_instr(idex_instr), .exmem_instr(exmem_instr),
        .ifid_pc(ifid_pc), .idex_pc(idex_pc),
        .ifid_valid(ifid_valid), .idex_valid(idex_valid), .exmem_valid(exmem_valid),
        .mem_stall(mem_stall), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic h, input logic fz, input logic fl,
                         input logic [31:0] instr, input logic [31:0] pcv);
        ihit = h; freeze = fz; flush = fl; imemload = instr; pc = pcv;
        #1;
    endtask

    task automatic adv(input logic [31:0] instr, input logic [31:0] pcv);
        drive(1'b1, 1'b0, 1'b0, instr, pcv);
        tick();
    endtask

    logic [31:0] snap_ifid, snap_idex, snap_exmem;
    logic        sat_changed;

    initial begin
        RST = 1'b1; dhit = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) tick();
        chk("rst_ifid", ifid_instr, 32'h0);
        chk("rst_valids", {29'd0, ifid_valid, idex_valid, exmem_valid}, 32'h0);
        chk("rst_cnts", {freeze_cnt, flush_cnt}, 32'h0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'h0);
        RST = 1'b0;

        // Straight-line advance
        drive(1'b1, 1'b0, 1'b0, 32'h20010001, 32'h0);
        chk("adv_pc_en0", {31'd0, pc_en}, 32'h1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h20020002, 32'h4);
        chk("adv_pc_en1", {31'd0, pc_en}, 32'h1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h20030003, 32'h8);
        chk("adv_pc_en2", {31'd0, pc_en}, 32'h1);
        tick();
        chk("adv_exmem", exmem_instr, 32'h20010001);
        chk("adv_idex", idex_instr, 32'h20020002);
        chk("adv_ifid", ifid_instr, 32'h20030003);
        chk("adv_ifid_pc", ifid_pc, 32'h8);
        chk("adv_idex_pc", idex_pc, 32'h4);
        chk("adv_valids", {29'd0, ifid_valid, idex_valid, exmem_valid}, 32'h7);

        // Load-use freeze
        adv(32'h8C020000, 32'hC);
        adv(32'h00421820, 32'h10);
        drive(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h14);
        chk("frz_pc_en", {31'd0, pc_en}, 32'h0);
        tick();
        chk("frz_idex", idex_instr, 32'h0);
        chk("frz_idex_v", {31'd0, idex_valid}, 32'h0);
        chk("frz_ifid", ifid_instr, 32'h00421820);
        chk("frz_ifid_pc", ifid_pc, 32'h10);
        chk("frz_exmem", exmem_instr, 32'h8C020000);
        chk("frz_cnt", {16'd0, freeze_cnt}, 32'h1);

        // Data memory stall on a SW in EX/MEM
        adv(32'hAC030004, 32'h14);
        adv(32'h00000020, 32'h18);
        adv(32'h3C040001, 32'h1C);
        chk("ms_setup", exmem_instr, 32'hAC030004);
        dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h55555555, 32'h20);
            chk("ms_stall", {31'd0, mem_stall}, 32'h1);
            chk("ms_pc_en", {31'd0, pc_en}, 32'h0);
            tick();
            chk("ms_ifid", ifid_instr, 32'h3C040001);
            chk("ms_idex", idex_instr, 32'h00000020);
            chk("ms_exmem", exmem_instr, 32'hAC030004);
            chk("ms_cnts", {freeze_cnt, flush_cnt}, 32'h0001_0000);
        end
        dhit = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h11111111, 32'h20);
        chk("ms_release", {31'd0, mem_stall}, 32'h0);
        tick();
        chk("ms_adv_exmem", exmem_instr, 32'h00000020);
        chk("ms_adv_idex", idex_instr, 32'h3C040001);
        chk("ms_adv_ifid", ifid_instr, 32'h11111111);

        // Flush beats freeze and a fetch miss
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h24);
        chk("fl_pc_en", {31'd0, pc_en}, 32'h1);
        tick();
        chk("fl_ifid", ifid_instr, 32'h0);
        chk("fl_idex", idex_instr, 32'h0);
        chk("fl_valids", {29'd0, ifid_valid, idex_valid, exmem_valid}, 32'h1);
        chk("fl_exmem", exmem_instr, 32'h3C040001);
        chk("fl_cnts", {freeze_cnt, flush_cnt}, 32'h0001_0001);

        // Fetch miss
        adv(32'h22222222, 32'h24);
        drive(1'b0, 1'b0, 1'b0, 32'h99999999, 32'h28);
        chk("miss_pc_en", {31'd0, pc_en}, 32'h0);
        tick();
        chk("miss_ifid", ifid_instr, 32'h0);
        chk("miss_idex", idex_instr, 32'h22222222);
        chk("miss_idex_pc", idex_pc, 32'h24);
        chk("miss_valids", {29'd0, ifid_valid, idex_valid, exmem_valid}, 32'h2);

        // Saturation of freeze_cnt; IF/ID must survive every bubble
        adv(32'h33333333, 32'h28);
        sat_changed = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h44444444, 32'h2C);
        for (int i = 0; i < 65534; i++) begin
            tick();
            if (ifid_instr !== 32'h33333333) sat_changed = 1'b1;
        end
        chk("sat_reach", {16'd0, freeze_cnt}, 32'hFFFF);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ifid_instr !== 32'h33333333) sat_changed = 1'b1;
        end
        chk("sat_hold", {16'd0, freeze_cnt}, 32'hFFFF);
        chk("sat_ifid_stable", {31'd0, sat_changed}, 32'h0);
        chk("sat_flush_cnt", {16'd0, flush_cnt}, 32'h1);

        // Asynchronous reset mid-run with a full pipe
        adv(32'h20050005, 32'h2C);
        adv(32'h20060006, 32'h30);
        adv(32'h20070007, 32'h34);
        chk("rr_full", {29'd0, ifid_valid, idex_valid, exmem_valid}, 32'h7);
        drive(1'b1, 1'b0, 1'b0, 32'h20080008, 32'h38);
        RST = 1'b1;
        #1;
        chk("rr_instrs", ifid_instr | idex_instr | exmem_instr, 32'h0);
        chk("rr_valids", {29'd0, ifid_valid, idex_valid, exmem_valid}, 32'h0);
        chk("rr_cnts", {freeze_cnt, flush_cnt}, 32'h0);
        chk("rr_pc_en", {31'd0, pc_en}, 32'h0);
        RST = 1'b0;
        adv(32'h20080008, 32'h38);
        chk("rr_after_ifid", ifid_instr, 32'h20080008);
        chk("rr_after_valids", {29'd0, ifid_valid, idex_valid, exmem_valid}, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_tracker.md
Name: pipe_hazard_tracker

Overview:
- Consumer end of the hazard-unit interface: takes `freeze`/`flush` plus memory hit status and applies them to the front-end pipeline latches.
- Holds the IF/ID, ID/EX and EX/MEM instruction/PC/valid registers.
- Feeds `ifid_instr`/`idex_instr`/`exmem_instr` back to the hazard unit.
- Drives the PC enable and keeps saturating stall/flush statistics.

Parameters:
- WORD_W, 32, instruction and PC width.
- NOP_WORD, 32'h00000000, value inserted for a bubble.
- CNT_W, 16, width of statistics counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction memory returned `imemload` this cycle.
- dhit  in  1  data memory completed the EX/MEM load/store this cycle.
- freeze  in  1  hazard unit load-use stall request.
- flush  in  1  hazard unit branch/jump squash request.
- imemload  in  WORD_W  fetched instruction.
- pc  in  WORD_W  current PC from the PC register.
- pc_en  out  1  PC may update this cycle.
- ifid_instr  out  WORD_W  IF/ID instruction.
- idex_instr  out  WORD_W  ID/EX instruction.
- exmem_instr  out  WORD_W  EX/MEM instruction.
- ifid_pc  out  WORD_W  IF/ID PC.
- idex_pc  out  WORD_W  ID/EX PC.
- ifid_valid  out  1  IF/ID holds a real instruction.
- idex_valid  out  1  ID/EX holds a real instruction.
- exmem_valid  out  1  EX/MEM holds a real instruction.
- mem_stall  out  1  whole pipe held waiting on data memory.
- freeze_cnt  out  CNT_W  cycles a freeze bubble was inserted.
- flush_cnt  out  CNT_W  cycles a flush was applied.

Behaviour:
- Reset (async, RST=1):
  - all instr regs = NOP_WORD; all PC regs = 0; all valid = 0.
  - counters = 0.
  - `pc_en` and `mem_stall` are combinational and therefore 0 after reset.
- `mem_stall` (combinational) = `exmem_valid` & (`exmem_instr[31:26]` is LW 6'b100011 or SW 6'b101011) & ~`dhit`.
- Per rising edge, first matching rule wins:
  1. HOLD (`mem_stall`=1): every register holds; `pc_en`=0; counters unchanged. `freeze`/`flush` are ignored this cycle.
  2. FLUSH (`flush`=1):
     - IF/ID <= NOP, valid 0.
     - ID/EX <= NOP, valid 0.
     - EX/MEM <= ID/EX contents (the resolving branch proceeds).
     - `pc_en`=1 regardless of `ihit`.
     - `flush_cnt`++.
     - Overrides `freeze`.
  3. FREEZE (`freeze`=1):
     - IF/ID holds.
     - ID/EX <= NOP, valid 0 (bubble).
     - EX/MEM <= ID/EX.
     - `pc_en`=0.
     - `freeze_cnt`++.
  4. FETCH-MISS (`ihit`=0):
     - IF/ID <= NOP, valid 0.
     - ID/EX <= IF/ID.
     - EX/MEM <= ID/EX.
     - `pc_en`=0.
  5. ADVANCE:
     - IF/ID <= {`imemload`, `pc`}, valid 1.
     - ID/EX <= IF/ID.
     - EX/MEM <= ID/EX.
     - `pc_en`=1.
- `pc_en` is combinational from the same priority: 0 in HOLD/FREEZE/FETCH-MISS, 1 in FLUSH/ADVANCE.
- Counters saturate at all-ones and never wrap.
- A bubble carries `instr`=NOP_WORD and valid=0. `exmem_instr` of a bubble (opcode 0) never raises `mem_stall`.
- `freeze` held for N consecutive cycles inserts N bubbles; the IF/ID contents survive all N.
- RST asserted mid-stall or mid-flush clears immediately and asynchronously. First edge after deassert follows the normal rules.

Test Plan:
- Reset mid-run:
  - Stimulus: RST=1 while pipe is full of valid instructions.
  - Required: all instr = 0, all valid = 0, counters = 0, `pc_en`=0, same cycle (asynchronous).
- Straight-line advance:
  - Stimulus: `ihit`=1, `pc`=0x0,0x4,0x8; `imemload`=0x20010001, 0x20020002, 0x20030003.
  - Required: after 3 edges `exmem_instr`=0x20010001, `idex_instr`=0x20020002, `ifid_instr`=0x20030003, `ifid_pc`=0x8; `pc_en`=1 throughout.
- Load-use freeze:
  - Stimulus: `idex_instr`=0x8C020000 (LW $2), `ifid_instr`=0x00421820; drive `freeze`=1 for one cycle.
  - Required: `pc_en`=0; next edge `idex_instr`=0 with `idex_valid`=0, `ifid_instr` still 0x00421820, `exmem_instr`=0x8C020000, `freeze_cnt`=1.
- Data memory stall:
  - Stimulus: `exmem_instr`=0xAC030004 (SW), `dhit`=0 for 3 cycles, with `freeze`=1 and `flush`=1 asserted during them.
  - Required: `mem_stall`=1, all registers unchanged and counters unchanged for 3 edges; advance on the edge where `dhit`=1.
- Flush priority:
  - Stimulus: `flush`=1, `freeze`=1, `ihit`=0 in the same cycle.
  - Required: `pc_en`=1; IF/ID and ID/EX become NOP/invalid; EX/MEM gets the prior ID/EX; `flush_cnt`+1, `freeze_cnt` unchanged.
- Saturation:
  - Stimulus: hold `freeze`=1 for 65540 cycles.
  - Required: `freeze_cnt` stops at 0xFFFF; IF/ID unchanged throughout.
